gray_conv_arbiter: RTL and testbench

- Shares one binary/Gray conversion datapath between two requesters.
- Round-robin arbitration; each request carries data plus a direction (bin->gray or gray->bin).
- A sequencing FSM captures the request, performs a registered conversion and returns the result with the requester ID over a valid/ready response channel.
- Sits between the counter/pointer logic (requesters) and the consumer of converted codes.

---
 rtl/gray_conv_arbiter_pkg.sv | 16 +
 rtl/gray_conv_arbiter_if.sv | 37 +++
 rtl/gray_conv_core.sv | 25 ++
 rtl/gray_conv_arbiter.sv | 112 +++++++++++
 tb/tb_gray_conv_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_conv_arbiter_pkg.sv
// Shared types and constants for the two-requester binary/Gray conversion arbiter.
package gray_conv_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic MODE_B2G = 1'b0;
   localparam logic MODE_G2B = 1'b1;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/gray_conv_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and the code consumer.
interface gray_conv_arbiter_if #(
   parameter int WIDTH = 4
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_data;
   logic             req0_mode;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_data;
   logic             req1_mode;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_id;
   logic             rsp_mode;
   logic             busy;

   // Requester/consumer side.
   modport master (
      output req0_valid, req0_data, req0_mode,
      output req1_valid, req1_data, req1_mode,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_data, rsp_id, rsp_mode, busy
   );

   // Arbiter side.
   modport slave (
      input  req0_valid, req0_data, req0_mode,
      input  req1_valid, req1_data, req1_mode,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_data, rsp_id, rsp_mode, busy
   );
endinterface

// File: rtl/gray_conv_core.sv
// Combinational binary<->Gray converter, direction chosen by mode; no width growth.
module gray_conv_core
   import gray_conv_arbiter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] operand,
   input  logic             mode,
   output logic [WIDTH-1:0] result
);

   always_comb begin
      result = '0;
      if (mode == MODE_B2G) begin
         result = operand ^ (operand >> 1);
      end else begin
         // Prefix XOR running down from the MSB.
         result[WIDTH-1] = operand[WIDTH-1];
         for (int i = WIDTH - 2; i >= 0; i--) begin
            result[i] = result[i+1] ^ operand[i];
         end
      end
   end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin shares one gray_conv_core between two requesters; one result per 3 cycles.
// GRAY_CONV_ARBITER_STATS_EN adds saturating per-requester completion counters cnt0/cnt1.
module gray_conv_arbiter
   import gray_conv_arbiter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   gray_conv_arbiter_if.slave  bus
`ifdef GRAY_CONV_ARBITER_STATS_EN
   ,
   output logic [15:0]         cnt0,
   output logic [15:0]         cnt1
`endif
);

   state_t           state;
   logic             last_grant;
   logic [WIDTH-1:0] op;
   logic             op_mode;
   logic             op_id;
   logic             grant0;
   logic             grant1;
   logic [WIDTH-1:0] conv_res;
   logic             rsp_valid;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_id;
   logic             rsp_mode;

   // Readies are offered only while idle; on a tie the side not served last wins.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == IDLE && rst_n) begin
         if (bus.req0_valid && bus.req1_valid) begin
            if (last_grant == REQ1) grant0 = 1'b1;
            else                    grant1 = 1'b1;
         end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
         end
      end
   end

   gray_conv_core #(.WIDTH(WIDTH)) u_core (
      .operand (op),
      .mode    (op_mode),
      .result  (conv_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= REQ1;
         op         <= '0;
         op_mode    <= MODE_B2G;
         op_id      <= REQ0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_id     <= REQ0;
         rsp_mode   <= MODE_B2G;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  op         <= grant1 ? bus.req1_data : bus.req0_data;
                  op_mode    <= grant1 ? bus.req1_mode : bus.req0_mode;
                  op_id      <= grant1 ? REQ1 : REQ0;
                  last_grant <= grant1 ? REQ1 : REQ0;
                  state      <= CONV;
               end
            end
            CONV: begin
               rsp_data  <= conv_res;
               rsp_id    <= op_id;
               rsp_mode  <= op_mode;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign bus.rsp_valid  = rsp_valid;
   assign bus.rsp_data   = rsp_data;
   assign bus.rsp_id     = rsp_id;
   assign bus.rsp_mode   = rsp_mode;
   assign bus.busy       = (state != IDLE);

`ifdef GRAY_CONV_ARBITER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else if (rsp_valid && bus.rsp_ready) begin
         if (rsp_id == REQ0 && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
         if (rsp_id == REQ1 && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter with a transaction-level reference model checked every cycle.
module tb_gray_conv_arbiter;

   localparam int W = 4;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;

   gray_conv_arbiter_if #(.WIDTH(W)) bus ();

`ifdef GRAY_CONV_ARBITER_STATS_EN
   logic [15:0] cnt0;
   logic [15:0] cnt1;
`endif

   gray_conv_arbiter #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
`ifdef GRAY_CONV_ARBITER_STATS_EN
      ,
      .cnt0  (cnt0),
      .cnt1  (cnt1)
`endif
   );

   logic [7:0] c8_op;
   logic       c8_mode;
   logic [7:0] c8_res;

   gray_conv_core #(.WIDTH(8)) u_core8 (
      .operand (c8_op),
      .mode    (c8_mode),
      .result  (c8_res)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference conversions written from the code definitions.
   function automatic logic [W-1:0] m_b2g(input logic [W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [W-1:0] m_g2b(input logic [W-1:0] g);
      logic [W-1:0] b;
      b = g;
      for (int s = 1; s < W; s = s * 2) b = b ^ (b >> s);
      return b;
   endfunction

   // Transaction model: free/in-flight, age since accept, last served side.
   bit           m_free;
   int           m_age;
   bit           m_last;
   logic [W-1:0] m_data;
   bit           m_id;
   bit           m_mode;
   int           grants[$];

   always @(negedge clk) begin
      bit e0, e1, ev;
      if (!rst_n) begin
         check("rst_req0_ready", bus.req0_ready, 0);
         check("rst_req1_ready", bus.req1_ready, 0);
         check("rst_rsp_valid",  bus.rsp_valid, 0);
         check("rst_busy",       bus.busy, 0);
         check("rst_rsp_data",   bus.rsp_data, 0);
         check("rst_rsp_id",     bus.rsp_id, 0);
         check("rst_rsp_mode",   bus.rsp_mode, 0);
         m_free = 1; m_last = 1; m_age = 0;
      end else begin
         e0 = 0; e1 = 0;
         if (m_free) begin
            if (bus.req0_valid && bus.req1_valid) begin
               e0 = (m_last == 1);
               e1 = (m_last == 0);
            end else begin
               e0 = bus.req0_valid;
               e1 = bus.req1_valid;
            end
         end
         ev = !m_free && m_age >= 2;
         check("req0_ready", bus.req0_ready, e0);
         check("req1_ready", bus.req1_ready, e1);
         check("busy",       bus.busy, !m_free);
         check("rsp_valid",  bus.rsp_valid, ev);
         if (ev) begin
            check("rsp_data", bus.rsp_data, m_data);
            check("rsp_id",   bus.rsp_id, m_id);
            check("rsp_mode", bus.rsp_mode, m_mode);
         end
         if (bus.req0_ready && bus.req1_ready) check("ready_onehot", 1, 0);
         if (bus.req0_ready) grants.push_back(0);
         if (bus.req1_ready) grants.push_back(1);
         if (e0 || e1) begin
            m_id   = e1;
            m_mode = e1 ? bus.req1_mode : bus.req0_mode;
            m_data = e1 ? bus.req1_data : bus.req0_data;
            m_data = m_mode ? m_g2b(m_data) : m_b2g(m_data);
            m_last = e1;
            m_free = 0;
            m_age  = 1;
         end else if (!m_free) begin
            if (ev && bus.rsp_ready) m_free = 1;
            else if (m_age < 2) m_age++;
         end
      end
   end

   task automatic send(input bit id, input logic [W-1:0] d, input bit m);
      int k;
      @(posedge clk); #1;
      if (id) begin bus.req1_valid = 1; bus.req1_data = d; bus.req1_mode = m; end
      else    begin bus.req0_valid = 1; bus.req0_data = d; bus.req0_mode = m; end
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(id ? bus.req1_ready : bus.req0_ready) && k < 100);
      if (k >= 100) check("send_timeout", 1, 0);
      @(posedge clk); #1;
      if (id) bus.req1_valid = 0;
      else    bus.req0_valid = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask

   initial begin
      int k;
      logic [W-1:0] sd;
      bit sid;
      n_cmp = 0; n_fail = 0;
      rst_n = 0;
      bus.req0_valid = 0; bus.req0_data = '0; bus.req0_mode = 0;
      bus.req1_valid = 0; bus.req1_data = '0; bus.req1_mode = 0;
      bus.rsp_ready = 1;
      c8_op = '0; c8_mode = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;

      // Single b2g from req0: value and 2-cycle latency.
      send(0, 4'b1011, 0);
      k = 0;
      do begin @(negedge clk); k++; end while (!bus.rsp_valid && k < 20);
      check("lat_b2g", k, 2);
      check("lit_b2g_data", bus.rsp_data, 4'b1110);
      check("lit_b2g_id", bus.rsp_id, 0);
      repeat (2) @(negedge clk);

      // Single g2b from req1.
      send(1, 4'b1110, 1);
      k = 0;
      do begin @(negedge clk); k++; end while (!bus.rsp_valid && k < 20);
      check("lat_g2b", k, 2);
      check("lit_g2b_data", bus.rsp_data, 4'b1011);
      check("lit_g2b_id", bus.rsp_id, 1);
      repeat (2) @(negedge clk);

      // Sweep every operand in both directions, alternating requesters.
      for (int v = 0; v < 16; v++)
         for (int m = 0; m < 2; m++)
            send(v[0] ^ m[0], v[W-1:0], m[0]);
      repeat (4) @(negedge clk);

      // Both pending after reset: strict alternation starting with req0.
      do_reset();
      grants.delete();
      fork
         for (int i = 0; i < 3; i++) send(0, 4'(i + 2), 0);
         for (int i = 0; i < 3; i++) send(1, 4'(i + 9), 1);
      join
      repeat (4) @(negedge clk);
      check("grant_count", grants.size(), 6);
      for (int i = 0; i < 6; i++)
         if (i < grants.size()) check("grant_order", grants[i], i % 2);

      // Consumer stall for 5 cycles in RESP with the other side waiting.
      bus.rsp_ready = 0;
      fork
         send(0, 4'h3, 0);
         send(1, 4'h5, 1);
         begin
            k = 0;
            do begin @(negedge clk); k++; end while (!bus.rsp_valid && k < 20);
            sd = bus.rsp_data; sid = bus.rsp_id;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               check("stall_valid", bus.rsp_valid, 1);
               check("stall_data", bus.rsp_data, sd);
               check("stall_id", bus.rsp_id, sid);
               check("stall_busy", bus.busy, 1);
               check("stall_ready", bus.req0_ready | bus.req1_ready, 0);
            end
            @(posedge clk); #1 bus.rsp_ready = 1;
         end
      join
      repeat (4) @(negedge clk);

      // Reset while in CONV: outputs clear at once, nothing stale afterwards.
      send(0, 4'h6, 0);
      rst_n = 0;
      #1;
      check("arst_valid", bus.rsp_valid, 0);
      check("arst_busy", bus.busy, 0);
      check("arst_data", bus.rsp_data, 0);
      check("arst_id", bus.rsp_id, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      repeat (8) @(negedge clk);
      grants.delete();
      fork
         send(0, 4'h1, 0);
         send(1, 4'h2, 0);
      join
      repeat (4) @(negedge clk);
      check("post_rst_first_grant", (grants.size() > 0) ? grants[0] : 9, 0);

      // Wider core instance.
      c8_op = 8'h80; c8_mode = 1; #1;
      check("core8_g2b", c8_res, 8'hFF);
      c8_op = 8'hFF; c8_mode = 0; #1;
      check("core8_b2g", c8_res, 8'h80);
      c8_op = 8'hC3; c8_mode = 0; #1;
      check("core8_b2g_c3", c8_res, 8'hA2);

`ifdef GRAY_CONV_ARBITER_STATS_EN
      do_reset();
      #1;
      check("cnt0_rst", cnt0, 0);
      check("cnt1_rst", cnt1, 0);
      for (int i = 0; i < 3; i++) send(0, 4'(i), 0);
      for (int i = 0; i < 2; i++) send(1, 4'(i), 1);
      repeat (4) @(negedge clk);
      check("cnt0", cnt0, 3);
      check("cnt1", cnt1, 2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
